fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, PC value loaded at reset.
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  hazard unit stall; hold PC and IF/ID.
REQ-005 flush_if  input  1  hazard unit flush; bubble IF/ID, redirect PC.
REQ-006 branchSel  input  1  taken branch; redirect target is branch_tgt.
REQ-007 jump  input  2  nonzero = jump; redirect target is jump_tgt.
REQ-008 branch_tgt, jump_tgt  input  32 each  redirect addresses.
REQ-009 ihit  input  1  instruction memory ready, same-cycle data.
REQ-010 iload  input  32  instruction word from memory.
REQ-011 imemREN  output  1  instruction read request.
REQ-012 imemaddr  output  32  read address, always equal to PC.
REQ-013 imemload_id  output  32  IF/ID instruction, drives hazard unit.
REQ-014 pc_id, npc_id  output  32 each  IF/ID PC and PC+4.
REQ-015 valid_id  output  1  IF/ID holds a real instruction.

Function
REQ-016 States: FETCH, HOLD, HALTED.
REQ-017 FETCH: imemREN=1. On ihit with stall=0: load IF/ID with {iload, PC, PC+4, valid=1}; PC<=PC+4. State stays FETCH.
REQ-018 FETCH, ihit with stall=1: capture iload in buffer; go HOLD. PC and IF/ID are unchanged.
REQ-019 HOLD: imemREN=0. When stall=0: load IF/ID from buffer; PC<=PC+4; go FETCH.
REQ-020 FETCH, no ihit: IF/ID holds if stall=1; otherwise it loads a bubble (instr 0, valid 0). PC is unchanged.
REQ-021 flush_if=1 in any state: IF/ID<=bubble and the buffer is discarded; go FETCH.
REQ-022 flush_if redirect target: branch_tgt if branchSel=1, else jump_tgt if jump!=0, else PC+4.
REQ-023 Priority: flush_if over stall over ihit; an ihit in a flush cycle is dropped.
REQ-024 PC+4 wraps modulo 2^32; bits [1:0] of PC are always 0 (targets masked).
REQ-025 HALT detection: when instruction 32'hFFFF_FFFF is loaded into IF/ID, go HALTED at the same edge.
REQ-026 HALTED: imemREN=0 and PC frozen. IF/ID keeps HALT. Exit only by flush_if (to FETCH) or reset.
REQ-027 Latency: one cycle from ihit to imemload_id update.

Reset
REQ-028 nRST=0 asynchronously sets state=FETCH, PC=PC_INIT, IF/ID=bubble (imemload_id=0, pc_id=0, npc_id=0, valid_id=0), and clears the buffer.
REQ-029 Reset mid-HOLD or mid-HALTED discards all state; the first fetch after release is at PC_INIT.

Configuration
REQ-030 Macro FETCH_PERF_EN defined: add outputs perf_stall_cnt[15:0] and perf_flush_cnt[15:0].
REQ-031 perf_stall_cnt counts cycles with stall=1; perf_flush_cnt counts cycles with flush_if=1. Both saturate at 16'hFFFF and reset to 0.
REQ-032 FETCH_PERF_EN undefined: these ports and counters do not exist, and all other behaviour is identical.

Verification
REQ-033 Reset release, ihit=1 every cycle, iload=32'h2001_0005: imemaddr sequence 0,4,8. Cycle 1 shows imemload_id=32'h2001_0005, pc_id=0, npc_id=4.
REQ-034 ihit with stall=1 for 3 cycles, iload=32'hAAAA_0001: imemREN=0 during HOLD. After stall drops, imemload_id=32'hAAAA_0001 and PC advances by 4 exactly once.
REQ-035 flush_if=1, branchSel=1, branch_tgt=32'h0000_0100, with stall=1 and ihit=1 in the same cycle: next imemaddr=32'h100, valid_id=0, imemload_id=0.
REQ-036 iload=32'hFFFF_FFFF: state HALTED and imemREN=0 for 10+ cycles. Then flush_if=1, jump=2'b10, jump_tgt=32'h40 gives imemaddr=32'h40 and imemREN=1.
REQ-037 PC=32'hFFFF_FFFC, ihit=1: next PC=0. Separately, nRST pulsed low mid-HOLD gives all outputs at reset values immediately, before the next clock edge.
REQ-038 With FETCH_PERF_EN: 70000 stall cycles give perf_stall_cnt=16'hFFFF, and it holds at that value.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, IF/ID pipeline latch, stall buffer and halt tracking.
// Optional macro FETCH_PERF_EN adds saturating stall/flush cycle counters.
module fetch_ctrl #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall,
  input  logic        flush_if,
  input  logic        branchSel,
  input  logic [1:0]  jump,
  input  logic [31:0] branch_tgt,
  input  logic [31:0] jump_tgt,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] imemload_id,
  output logic [31:0] pc_id,
  output logic [31:0] npc_id,
  output logic        valid_id
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_RESET   = {PC_INIT[31:2], 2'b00};

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] npc_id_q, npc_id_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] buf_q, buf_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_raw;
  logic [31:0] redirect_tgt;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    redirect_raw = pc_plus4;
    if (branchSel) begin
      redirect_raw = branch_tgt;
    end else if (jump != 2'b00) begin
      redirect_raw = jump_tgt;
    end
    redirect_tgt = {redirect_raw[31:2], 2'b00};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FETCH;
      pc_q       <= PC_RESET;
      instr_id_q <= 32'h0;
      pc_id_q    <= 32'h0;
      npc_id_q   <= 32'h0;
      valid_id_q <= 1'b0;
      buf_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_id_q <= instr_id_d;
      pc_id_q    <= pc_id_d;
      npc_id_q   <= npc_id_d;
      valid_id_q <= valid_id_d;
      buf_q      <= buf_d;
    end
  end

  // Flush dominates everything; otherwise stall freezes IF/ID and PC, and a
  // stalled hit parks its word in the buffer until the stall drops.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    npc_id_d   = npc_id_q;
    valid_id_d = valid_id_q;
    buf_d      = buf_q;

    if (flush_if) begin
      state_d    = FETCH;
      pc_d       = redirect_tgt;
      instr_id_d = 32'h0;
      pc_id_d    = 32'h0;
      npc_id_d   = 32'h0;
      valid_id_d = 1'b0;
      buf_d      = 32'h0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (stall) begin
            if (ihit) begin
              buf_d   = iload;
              state_d = HOLD;
            end
          end else if (ihit) begin
            instr_id_d = iload;
            pc_id_d    = pc_q;
            npc_id_d   = pc_plus4;
            valid_id_d = 1'b1;
            pc_d       = pc_plus4;
            if (iload == HALT_INSTR) begin
              state_d = HALTED;
            end
          end else begin
            instr_id_d = 32'h0;
            pc_id_d    = 32'h0;
            npc_id_d   = 32'h0;
            valid_id_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_id_d = buf_q;
            pc_id_d    = pc_q;
            npc_id_d   = pc_plus4;
            valid_id_d = 1'b1;
            pc_d       = pc_plus4;
            buf_d      = 32'h0;
            state_d    = (buf_q == HALT_INSTR) ? HALTED : FETCH;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  assign imemREN     = (state_q == FETCH);
  assign imemaddr    = pc_q;
  assign imemload_id = instr_id_q;
  assign pc_id       = pc_id_q;
  assign npc_id      = npc_id_q;
  assign valid_id    = valid_id_q;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_if && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
